// File: rtl/alu_job_sequencer.sv
// alu_job_sequencer: takes host jobs and runs each through the start/done ALU handshake, then returns the result.
// Define SEQ_TIMEOUT_EN to abort a job stuck in REQ/REL after TIMEOUT_CYCLES cycles.
module alu_job_sequencer #(
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic              job_op,
   input  logic [DATA_W-1:0] job_a,
   input  logic [DATA_W-1:0] job_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic [15:0]       job_count,
   output logic              proc_start,
   output logic              proc_op_sel,
   output logic [DATA_W-1:0] proc_a,
   output logic [DATA_W-1:0] proc_b,
   input  logic [DATA_W-1:0] proc_result,
   input  logic              proc_done
);
   typedef enum logic [1:0] {IDLE, REQ, REL, RSP} state_t;
   state_t state;
   // a stale done from the processor must clear before a new job can start
   assign job_ready = state == IDLE && !proc_done;
   assign busy      = state != IDLE;
`ifdef SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] cnt;
   logic          expired;
   assign expired = cnt == LAST;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state       <= IDLE;
         proc_start  <= 1'b0;
         proc_op_sel <= 1'b0;
         proc_a      <= '0;
         proc_b      <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         job_count   <= '0;
`ifdef SEQ_TIMEOUT_EN
         cnt         <= '0;
`endif
      end else
         case (state)
            IDLE:
               if (job_valid && job_ready) begin
                  proc_op_sel <= job_op;
                  proc_a      <= job_a;
                  proc_b      <= job_b;
                  proc_start  <= 1'b1;
                  state       <= REQ;
`ifdef SEQ_TIMEOUT_EN
                  cnt         <= '0;
`endif
               end
            REQ:
               if (proc_done) begin
                  rsp_data   <= proc_result;
                  rsp_err    <= 1'b0;
                  proc_start <= 1'b0;
                  state      <= REL;
`ifdef SEQ_TIMEOUT_EN
                  cnt        <= '0;
               end else if (expired) begin
                  rsp_data   <= '0;
                  rsp_err    <= 1'b1;
                  proc_start <= 1'b0;
                  state      <= REL;
                  cnt        <= '0;
               end else begin
                  cnt        <= cnt + 1'b1;
`endif
               end
            REL:
               if (!proc_done) begin
                  rsp_valid <= 1'b1;
                  state     <= RSP;
`ifdef SEQ_TIMEOUT_EN
               end else if (expired) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RSP;
               end else begin
                  cnt       <= cnt + 1'b1;
`endif
               end
            RSP:
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  job_count <= job_count + 16'd1;
                  state     <= IDLE;
               end
         endcase
endmodule

// File: tb/tb_alu_job_sequencer.sv
// tb_alu_job_sequencer: drives alu_job_sequencer against a 4-state add/sub processor model and checks
// responses, latency and handshake rules against an arithmetic reference.
module tb_alu_job_sequencer;
   logic clk = 1'b0, rst = 1'b1, job_valid = 1'b0, job_op = 1'b0, rsp_ready = 1'b0;
   logic [7:0] job_a = '0, job_b = '0;
   logic job_ready, rsp_valid, rsp_err, busy, proc_start, proc_op_sel, proc_done;
   logic [7:0] rsp_data, proc_a, proc_b, proc_result;
   logic [15:0] job_count;
   logic tie_mode = 1'b0, tie_val = 1'b0;
   typedef enum logic [1:0] {P_IDLE, P_LOAD, P_EXEC, P_DONE} pst_t;
   pst_t ps;
   logic m_done;
   logic [7:0] m_res;
   int checks = 0, failures = 0, exp_cnt = 0, lat, bad;
   logic [7:0] ra, rb;
   logic ro;

   assign proc_done   = tie_mode ? tie_val : m_done;
   assign proc_result = m_res;

   alu_job_sequencer #(.DATA_W(8), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job_op(job_op),
      .job_a(job_a), .job_b(job_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .job_count(job_count),
      .proc_start(proc_start), .proc_op_sel(proc_op_sel), .proc_a(proc_a), .proc_b(proc_b),
      .proc_result(proc_result), .proc_done(proc_done)
   );

   always #5 clk = ~clk;

   // processor: samples start in IDLE, done is a registered copy of the DONE state
   always @(posedge clk or posedge rst)
      if (rst) begin
         ps <= P_IDLE;
         m_done <= 1'b0;
         m_res <= '0;
      end else begin
         m_done <= ps == P_DONE;
         case (ps)
            P_IDLE: if (proc_start) ps <= P_LOAD;
            P_LOAD: ps <= P_EXEC;
            P_EXEC: begin
               ps <= P_DONE;
               m_res <= proc_op_sel ? proc_a - proc_b : proc_a + proc_b;
            end
            P_DONE: if (!proc_start) ps <= P_IDLE;
         endcase
      end

   function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic op);
      int r;
      r = op ? (int'(a) - int'(b) + 256) % 256 : (int'(a) + int'(b)) % 256;
      return r[7:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic op);
      int n;
      @(negedge clk);
      job_valid = 1'b1;
      job_a = a;
      job_b = b;
      job_op = op;
      n = 0;
      while (!job_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", n < 50, 1);
      @(posedge clk);
      @(negedge clk);
      job_valid = 1'b0;
      chk("start_hi", proc_start, 1);
      chk("proc_ops", {proc_op_sel, proc_a, proc_b}, {op, a, b});
      chk("busy_hi", busy, 1);
   endtask

   task automatic wait_rsp(output int l);
      int b;
      l = 0;
      b = 0;
      while (!rsp_valid && l < 100) begin
         if (job_ready) b++;
         @(negedge clk);
         l++;
      end
      chk("no_overlap", b, 0);
   endtask

   task automatic take(input int hold);
      logic [7:0] d;
      logic e;
      int b;
      d = rsp_data;
      e = rsp_err;
      b = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_data !== d || rsp_err !== e || job_ready) b++;
      end
      if (hold > 0) chk("rsp_hold", b, 0);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_cnt++;
      chk("rsp_drop", rsp_valid, 0);
      chk("job_count", job_count, exp_cnt);
      chk("busy_idle", busy, 0);
   endtask

   task automatic job(input logic [7:0] a, input logic [7:0] b, input logic op, input int hold,
                      input logic early, input logic [7:0] exp);
      int l;
      rsp_ready = early;
      accept(a, b, op);
      wait_rsp(l);
      chk("latency", l, 8);
      chk("rsp_data", rsp_data, exp);
      chk("rsp_err", rsp_err, 0);
      take(early ? 0 : hold);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_outs", {rsp_valid, rsp_err, busy, proc_start, proc_op_sel}, 0);
      chk("rst_data", {rsp_data, proc_a, proc_b, job_count}, 0);
      chk("rst_ready", job_ready, 1);
      rst = 1'b0;
      // basic, wrap-around and early rsp_ready
      job(8'h12, 8'h05, 1'b0, 0, 1'b1, 8'h17);
      chk("count_one", job_count, 1);
      job(8'h05, 8'h07, 1'b1, 0, 1'b0, 8'hFE);
      job(8'hFF, 8'h02, 1'b0, 0, 1'b0, 8'h01);
      // response back-pressure with next job already offered
      accept(8'h21, 8'h10, 1'b1);
      wait_rsp(lat);
      chk("bp_latency", lat, 8);
      chk("bp_data", rsp_data, 8'h11);
      job_a = 8'h40;
      job_b = 8'h02;
      job_op = 1'b0;
      job_valid = 1'b1;
      take(5);
      chk("b2b_ready", job_ready, 1);
      @(posedge clk);
      @(negedge clk);
      job_valid = 1'b0;
      chk("b2b_accept", {busy, proc_start, proc_a}, {1'b1, 1'b1, 8'h40});
      wait_rsp(lat);
      chk("b2b_latency", lat, 8);
      chk("b2b_data", rsp_data, 8'h42);
      take(0);
      // stale proc_done blocks acceptance
      @(negedge clk);
      tie_mode = 1'b1;
      tie_val = 1'b1;
      job_a = 8'h30;
      job_b = 8'h31;
      job_op = 1'b0;
      job_valid = 1'b1;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (job_ready || busy) bad++;
      end
      chk("stale_block", bad, 0);
      tie_val = 1'b0;
      tie_mode = 1'b0;
      #1 chk("release_ready", job_ready, 1);
      @(posedge clk);
      @(negedge clk);
      job_valid = 1'b0;
      chk("release_accept", {busy, proc_start}, 2'b11);
      wait_rsp(lat);
      chk("release_latency", lat, 8);
      chk("release_data", rsp_data, 8'h61);
      take(0);
      // proc_done tied low
      tie_mode = 1'b1;
      tie_val = 1'b0;
      accept(8'h0A, 8'h0B, 1'b0);
`ifdef SEQ_TIMEOUT_EN
      lat = 1;
      while (proc_start && lat < 50) begin
         @(negedge clk);
         if (proc_start) lat++;
      end
      chk("to_start_cycles", lat, 8);
      wait_rsp(lat);
      chk("to_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b1, 8'h00});
      take(0);
`else
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!proc_start || rsp_valid || rsp_err || !busy) bad++;
      end
      chk("hang_wait", bad, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
`endif
      tie_mode = 1'b0;
      // reset while in REQ
      accept(8'h33, 8'h44, 1'b0);
      rst = 1'b1;
      #1 chk("rst_mid", {proc_start, busy, rsp_valid}, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      chk("rst_mid_count", job_count, 0);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid || busy) bad++;
      end
      chk("rst_no_rsp", bad, 0);
      job(8'h33, 8'h44, 1'b0, 1, 1'b0, 8'h77);
      // randomized jobs against the reference
      for (int k = 0; k < 16; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         ro = 1'($urandom);
         job(ra, rb, ro, int'($urandom_range(0, 3)), 1'($urandom), ref_alu(ra, rb, ro));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
